// File: rtl/core_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : core_apb_bridge
// Purpose  : Single-outstanding APB4 initiator. Turns valid/ready requests
//            from the core load/store unit into APB SETUP/ACCESS sequences
//            and returns one response per request. A wait-state timeout
//            aborts transfers whose completer never raises pready.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            req_*                - request channel (valid/ready)
//            resp_*               - response channel (valid/ready)
//            psel .. pwdata       - registered APB master outputs
//            prdata, pslverr,
//            pready               - APB completer responses
// Revision : 1.0 - initial release
// ============================================================================
module core_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_strb,
    input  logic [2:0]            req_prot,
    // response channel
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    // APB master
    output logic                  psel,
    output logic                  penable,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [3:0]            pstrb,
    output logic [2:0]            pprot,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata,
    input  logic                  pslverr,
    input  logic                  pready
);

    // Wait counter is at least one bit wide even when the timeout is disabled.
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last =
        (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    logic [1:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [3:0]            r_pstrb;
    logic [2:0]            r_pprot;
    logic [31:0]           r_pwdata;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic                  w_timeout_hit;

    // Last permitted wait cycle; pready is checked first so it wins a tie.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == c_to_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pstrb      <= 4'h0;
            r_pprot      <= 3'h0;
            r_pwdata     <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_paddr   <= req_addr;
                        r_pwrite  <= req_write;
                        r_pwdata  <= req_wdata;
                        r_pprot   <= req_prot;
                        // Reads never carry strobes on APB4.
                        r_pstrb   <= req_write ? req_strb : 4'h0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= c_st_access;
                end
                c_st_access: begin
                    if (pready) begin
                        r_resp_err   <= pslverr;
                        r_resp_rdata <= r_pwrite ? 32'h0 : prdata;
                        r_resp_valid <= 1'b1;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_state      <= c_st_resp;
                    end else if (w_timeout_hit) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'h0;
                        r_resp_valid <= 1'b1;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_state      <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == c_st_idle);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign paddr      = r_paddr;
    assign pwrite     = r_pwrite;
    assign pstrb      = r_pstrb;
    assign pprot      = r_pprot;
    assign pwdata     = r_pwdata;

endmodule
`default_nettype wire
